// File: rtl/irig_frame_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : irig_frame_tracker_if
//  Purpose  : Symbol inputs from the IRIG classifier and the frame-tracking
//             outputs of irig_frame_tracker, bundled as one interface.
//  Revision : 1.0  initial release
// ============================================================================
interface irig_frame_tracker_if;
    logic       irig_d0;
    logic       irig_d1;
    logic       irig_mark;
    logic       locked;
    logic       pps_gate;
    logic       bit_valid;
    logic [3:0] field_idx;
    logic [3:0] bit_pos;
    logic       bit_value;
    logic       frame_err;
    logic [3:0] err_cnt;

    // Symbol source side (classifier / bench)
    modport master (
        output irig_d0, irig_d1, irig_mark,
        input  locked, pps_gate, bit_valid, field_idx, bit_pos, bit_value,
               frame_err, err_cnt
    );

    // Tracker side
    modport slave (
        input  irig_d0, irig_d1, irig_mark,
        output locked, pps_gate, bit_valid, field_idx, bit_pos, bit_value,
               frame_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/irig_frame_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : irig_frame_tracker
//  Purpose  : Locates the IRIG double-mark frame boundary, indexes every data
//             symbol by field/position, checks mark placement and keeps lock
//             with a per-frame flywheel error budget.
//  Revision : 1.0  initial release
// ============================================================================
module irig_frame_tracker #(
    parameter int FIELDS      = 10,
    parameter int FIELD_LEN   = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_LIMIT   = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    irig_frame_tracker_if.slave   bus
);

    localparam logic [1:0] c_S_UNLOCKED = 2'd0;
    localparam logic [1:0] c_S_SYNC     = 2'd1;
    localparam logic [1:0] c_S_ACQUIRE  = 2'd2;
    localparam logic [1:0] c_S_LOCKED   = 2'd3;

    localparam logic [3:0] c_FIELD_LAST  = 4'(FIELDS - 1);
    localparam logic [3:0] c_SYM_LAST    = 4'(FIELD_LEN - 1);
    localparam logic [3:0] c_LOCK_FRAMES = 4'(LOCK_FRAMES);
    localparam logic [3:0] c_ERR_LIMIT   = 4'(ERR_LIMIT);

    logic [1:0] r_state;
    logic [3:0] r_fcnt;
    logic [3:0] r_scnt;
    logic [3:0] r_lock_cnt;
    logic [3:0] r_err_cnt;
    logic       r_pps;
    logic       r_bit_valid;
    logic [3:0] r_field_idx;
    logic [3:0] r_bit_pos;
    logic       r_bit_value;
    logic       r_frame_err;

    logic       w_sym;
    logic       w_multi;
    logic       w_mark;
    logic       w_data;
    logic       w_ref_pos;
    logic       w_mark_exp;
    logic       w_err;
    logic       w_ref_ok;
    logic       w_err_drop;
    logic [3:0] w_fcnt_nxt;
    logic [3:0] w_scnt_nxt;

    // Symbol classification: multi-hot counts as one symbol that is always an error
    assign w_sym      = bus.irig_d0 | bus.irig_d1 | bus.irig_mark;
    assign w_multi    = (bus.irig_d0 & bus.irig_d1) | (bus.irig_d0 & bus.irig_mark)
                      | (bus.irig_d1 & bus.irig_mark);
    assign w_mark     = bus.irig_mark & ~w_multi;
    assign w_data     = (bus.irig_d0 | bus.irig_d1) & ~w_multi;
    assign w_ref_pos  = (r_fcnt == 4'd0) && (r_scnt == 4'd0);
    assign w_mark_exp = w_ref_pos || (r_scnt == c_SYM_LAST);
    assign w_err      = w_multi | (w_mark & ~w_mark_exp) | (w_data & w_mark_exp);
    assign w_ref_ok   = w_ref_pos & w_mark;
    assign w_err_drop = w_err && ((r_err_cnt + 4'd1) == c_ERR_LIMIT);

    // Position of the symbol after the current one
    always_comb begin
        w_fcnt_nxt = r_fcnt;
        w_scnt_nxt = r_scnt + 4'd1;
        if (r_scnt == c_SYM_LAST) begin
            w_scnt_nxt = 4'd0;
            w_fcnt_nxt = (r_fcnt == c_FIELD_LAST) ? 4'd0 : r_fcnt + 4'd1;
        end
    end

    // Frame-sync state machine, position counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_UNLOCKED;
            r_fcnt      <= 4'd0;
            r_scnt      <= 4'd0;
            r_lock_cnt  <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_pps       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_field_idx <= 4'd0;
            r_bit_pos   <= 4'd0;
            r_bit_value <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_pps       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_sym) begin
                case (r_state)
                    c_S_UNLOCKED: begin
                        if (w_mark) r_state <= c_S_SYNC;
                    end
                    c_S_SYNC: begin
                        if (w_mark) begin
                            // second mark of the pair is the reference mark
                            r_state    <= c_S_ACQUIRE;
                            r_fcnt     <= 4'd0;
                            r_scnt     <= 4'd1;
                            r_lock_cnt <= 4'd0;
                        end else begin
                            r_state     <= c_S_UNLOCKED;
                            r_frame_err <= 1'b1;
                        end
                    end
                    c_S_ACQUIRE: begin
                        if (w_err) begin
                            r_state     <= c_S_UNLOCKED;
                            r_frame_err <= 1'b1;
                            r_fcnt      <= 4'd0;
                            r_scnt      <= 4'd0;
                        end else begin
                            r_fcnt <= w_fcnt_nxt;
                            r_scnt <= w_scnt_nxt;
                            if (w_ref_ok) begin
                                if ((r_lock_cnt + 4'd1) == c_LOCK_FRAMES) begin
                                    r_state   <= c_S_LOCKED;
                                    r_pps     <= 1'b1;
                                    r_err_cnt <= 4'd0;
                                end else begin
                                    r_lock_cnt <= r_lock_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    default: begin  // c_S_LOCKED
                        if (w_err) r_frame_err <= 1'b1;
                        if (w_err_drop) begin
                            r_state   <= c_S_UNLOCKED;
                            r_err_cnt <= 4'd0;
                            r_fcnt    <= 4'd0;
                            r_scnt    <= 4'd0;
                        end else begin
                            // flywheel: keep counting through tolerated errors
                            r_fcnt <= w_fcnt_nxt;
                            r_scnt <= w_scnt_nxt;
                            if (w_ref_pos)  r_err_cnt <= 4'd0;
                            else if (w_err) r_err_cnt <= r_err_cnt + 4'd1;
                            if (w_ref_ok)   r_pps     <= 1'b1;
                        end
                    end
                endcase
                // data index is captured only for clean data in the tracking states
                if (w_data && !w_err &&
                    (r_state == c_S_ACQUIRE || r_state == c_S_LOCKED)) begin
                    r_bit_valid <= 1'b1;
                    r_field_idx <= r_fcnt;
                    r_bit_pos   <= r_scnt;
                    r_bit_value <= bus.irig_d1;
                end
            end
        end
    end

    assign bus.locked    = (r_state == c_S_LOCKED);
    assign bus.pps_gate  = r_pps;
    assign bus.bit_valid = r_bit_valid;
    assign bus.field_idx = r_field_idx;
    assign bus.bit_pos   = r_bit_pos;
    assign bus.bit_value = r_bit_value;
    assign bus.frame_err = r_frame_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
